// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, address field layout and write FSM states
package sdram_pkg;

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AREF       = 4'b0001;
  localparam logic [3:0] CMD_MRS        = 4'b0000;

  localparam int BANK_W     = 2;
  localparam int ROW_W      = 13;
  localparam int COL_W      = 9;
  localparam int COL_LSB    = 0;
  localparam int ROW_LSB    = COL_LSB + COL_W;
  localparam int BANK_LSB   = ROW_LSB + ROW_W;
  localparam int PAGE_WORDS = 512;

  localparam logic [1:0]  BA_IDLE    = 2'b11;
  localparam logic [12:0] ADDR_IDLE  = 13'h1fff;
  localparam logic [12:0] ADDR_A10   = 13'h0400;

  typedef enum logic [3:0] {
    WR_IDLE,
    WR_ACT,
    WR_TRCD,
    WR_WR,
    WR_DATA,
    WR_TWR,
    WR_PRE,
    WR_TRP,
    WR_END
  } wr_state_t;

  // Map a requested burst length onto the legal 1..PAGE_WORDS range.
  function automatic logic [9:0] clamp_len(input logic [9:0] len);
    if (len == 10'd0)
      return 10'd1;
    else if (len > 10'(PAGE_WORDS))
      return 10'(PAGE_WORDS);
    else
      return len;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// rtl/sdram_wait_cnt.sv - loadable down-counter with done flag for SDRAM timing waits
module sdram_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - SDRAM full-page write-burst engine; optional page clipping under SDRAM_WR_PAGE_CLIP_EN
module sdram_write
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = 2,
  parameter int TWR_CLK  = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [23:0] wr_addr,
  input  logic [9:0]  wr_burst_len,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  wr_cmd,
  output logic [1:0]  wr_bank_addr,
  output logic [12:0] wr_sdram_addr,
`ifdef SDRAM_WR_PAGE_CLIP_EN
  output logic        wr_clip,
`endif
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  // Wait-counter reload values: each wait state lasts (value + 1) clocks.
  localparam logic [7:0] TRCD_LD = (TRCD_CLK > 1) ? 8'(TRCD_CLK - 2) : 8'd0;
  localparam logic [7:0] TWR_LD  = (TWR_CLK > 0)  ? 8'(TWR_CLK - 1)  : 8'd0;
  localparam logic [7:0] TRP_LD  = (TRP_CLK > 1)  ? 8'(TRP_CLK - 2)  : 8'd0;

  wr_state_t state, next_state;

  logic [BANK_W-1:0] bank_r;
  logic [ROW_W-1:0]  row_r;
  logic [COL_W-1:0]  col_r;
  logic [9:0]        len_r;
  logic [9:0]        len_req;
  logic [9:0]        len_eff;
  logic [9:0]        data_cnt;
  logic              data_phase_d;
  logic              start;
  logic              wait_load;
  logic [7:0]        wait_val;
  logic              wait_done;

`ifdef SDRAM_WR_PAGE_CLIP_EN
  logic       clip_req;
  logic       clip_r;
  logic [9:0] page_left;
`endif

  assign start = (state == WR_IDLE) && wr_en && init_end;

  // Effective burst length (and page clipping when enabled) from the request
  always_comb begin
    len_req = clamp_len(wr_burst_len);
    len_eff = len_req;
`ifdef SDRAM_WR_PAGE_CLIP_EN
    clip_req  = 1'b0;
    page_left = 10'(PAGE_WORDS) - {1'b0, wr_addr[COL_LSB +: COL_W]};
    if (len_req > page_left) begin
      len_eff  = page_left;
      clip_req = 1'b1;
    end
`endif
  end

  // Capture the burst descriptor on grant; held constant for the whole burst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_r <= '0;
      row_r  <= '0;
      col_r  <= '0;
      len_r  <= 10'd1;
`ifdef SDRAM_WR_PAGE_CLIP_EN
      clip_r <= 1'b0;
`endif
    end else if (start) begin
      bank_r <= wr_addr[BANK_LSB +: BANK_W];
      row_r  <= wr_addr[ROW_LSB +: ROW_W];
      col_r  <= wr_addr[COL_LSB +: COL_W];
      len_r  <= len_eff;
`ifdef SDRAM_WR_PAGE_CLIP_EN
      clip_r <= clip_req;
`endif
    end
  end

  // Count words written; zero outside the data phase so each burst starts clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_cnt     <= '0;
      data_phase_d <= 1'b0;
    end else begin
      data_cnt     <= ((state == WR_WR) || (state == WR_DATA)) ? data_cnt + 10'd1 : 10'd0;
      data_phase_d <= (state == WR_WR) || (state == WR_DATA);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= WR_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and wait-counter reload on entry to each timed state
  always_comb begin
    next_state = state;
    unique case (state)
      WR_IDLE: if (start) next_state = WR_ACT;
      WR_ACT:  next_state = (TRCD_CLK > 1) ? WR_TRCD : WR_WR;
      WR_TRCD: if (wait_done) next_state = WR_WR;
      WR_WR:   next_state = (len_r == 10'd1) ? WR_TWR : WR_DATA;
      WR_DATA: if (data_cnt == len_r - 10'd1) next_state = WR_TWR;
      WR_TWR:  if (wait_done) next_state = WR_PRE;
      WR_PRE:  next_state = (TRP_CLK > 1) ? WR_TRP : WR_END;
      WR_TRP:  if (wait_done) next_state = WR_END;
      WR_END:  next_state = WR_IDLE;
      default: next_state = WR_IDLE;
    endcase

    wait_load = 1'b0;
    wait_val  = 8'd0;
    if (next_state != state) begin
      unique case (next_state)
        WR_TRCD: begin wait_load = 1'b1; wait_val = TRCD_LD; end
        WR_TWR:  begin wait_load = 1'b1; wait_val = TWR_LD;  end
        WR_TRP:  begin wait_load = 1'b1; wait_val = TRP_LD;  end
        default: begin wait_load = 1'b0; wait_val = 8'd0;    end
      endcase
    end
  end

  sdram_wait_cnt #(.W(8)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (wait_load),
    .load_val (wait_val),
    .done     (wait_done)
  );

  // Moore-decoded command/address/data outputs
  always_comb begin
    wr_cmd        = CMD_NOP;
    wr_bank_addr  = BA_IDLE;
    wr_sdram_addr = ADDR_IDLE;
    wr_ack        = 1'b0;
    wr_end        = 1'b0;
    wr_sdram_en   = 1'b0;
    wr_sdram_data = 16'h0000;
    unique case (state)
      WR_ACT: begin
        wr_cmd        = CMD_ACTIVE;
        wr_bank_addr  = bank_r;
        wr_sdram_addr = row_r;
      end
      WR_WR: begin
        wr_cmd        = CMD_WRITE;
        wr_bank_addr  = bank_r;
        wr_sdram_addr = {4'b0000, col_r};
        wr_ack        = 1'b1;
        wr_sdram_en   = 1'b1;
        wr_sdram_data = wr_data;
      end
      WR_DATA: begin
        wr_ack        = 1'b1;
        wr_sdram_en   = 1'b1;
        wr_sdram_data = wr_data;
      end
      WR_TWR: begin
        if (data_phase_d) wr_cmd = CMD_BURST_STOP;
      end
      WR_PRE: begin
        wr_cmd        = CMD_PRECHARGE;
        wr_bank_addr  = bank_r;
        wr_sdram_addr = ADDR_A10;
      end
      WR_END: begin
        wr_end = 1'b1;
      end
      default: begin
        wr_cmd = CMD_NOP;
      end
    endcase
  end

`ifdef SDRAM_WR_PAGE_CLIP_EN
  assign wr_clip = (state == WR_END) && clip_r;
`endif

endmodule

// File: tb/tb_sdram_write.sv
// tb/tb_sdram_write.sv - scoreboard testbench for sdram_write
module tb_sdram_write;
  import sdram_pkg::*;

  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_burst_len;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_bank_addr;
  logic [12:0] wr_sdram_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
`ifdef SDRAM_WR_PAGE_CLIP_EN
  logic        wr_clip;
`endif

  sdram_write #(.TRCD_CLK(TRCD), .TWR_CLK(TWR), .TRP_CLK(TRP)) dut (
    .clk           (clk),
    .rst           (rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_burst_len  (wr_burst_len),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end),
    .wr_cmd        (wr_cmd),
    .wr_bank_addr  (wr_bank_addr),
    .wr_sdram_addr (wr_sdram_addr),
`ifdef SDRAM_WR_PAGE_CLIP_EN
    .wr_clip       (wr_clip),
`endif
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ack;
    logic        en;
    logic [15:0] data;
    logic        endp;
    logic        clip;
    int          gap;
  } evt_t;

  evt_t exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_cyc = 0;
  int ack_seen = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic push(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                      input logic ack, input logic en, input logic [15:0] data,
                      input logic endp, input logic clip, input int gap);
    evt_t e;
    e.cmd = cmd; e.ba = ba; e.addr = addr; e.ack = ack; e.en = en;
    e.data = data; e.endp = endp; e.clip = clip; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-idle output cycle is popped from the scoreboard and compared
  always @(negedge clk) begin
    evt_t e;
    cyc++;
    if (!rst && (wr_cmd != CMD_NOP || wr_ack || wr_end || wr_sdram_en)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_evt: got cmd=%b ack=%b end=%b en=%b expected no activity (cyc %0d)",
                 wr_cmd, wr_ack, wr_end, wr_sdram_en, cyc);
      end else begin
        e = exp_q.pop_front();
        check("evt", {wr_cmd, wr_bank_addr, wr_sdram_addr, wr_ack, wr_sdram_en, wr_sdram_data, wr_end},
                     {e.cmd, e.ba, e.addr, e.ack, e.en, e.data, e.endp});
        if (e.gap >= 0) check("gap", 64'(cyc - last_cyc), 64'(e.gap));
`ifdef SDRAM_WR_PAGE_CLIP_EN
        if (e.endp) check("clip", 64'(wr_clip), 64'(e.clip));
`endif
      end
      last_cyc = cyc;
      if (wr_ack) begin
        ack_seen++;
        wr_data = wr_data + 16'd1;
      end
    end
  end

  task automatic push_burst(input logic [1:0] bank, input logic [12:0] row, input logic [8:0] col,
                            input int exp_l, input logic exp_clip, input logic [15:0] base,
                            input int n_ack_evts, input bit tail);
    push(CMD_ACTIVE, bank, row, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1);
    push(CMD_WRITE, bank, {4'b0000, col}, 1'b1, 1'b1, base, 1'b0, 1'b0, TRCD);
    for (int i = 1; i < n_ack_evts; i++)
      push(CMD_NOP, 2'b11, 13'h1fff, 1'b1, 1'b1, base + 16'(i), 1'b0, 1'b0, 1);
    if (tail) begin
      push(CMD_BURST_STOP, 2'b11, 13'h1fff, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1);
      push(CMD_PRECHARGE, bank, 13'h0400, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, TWR);
      push(CMD_NOP, 2'b11, 13'h1fff, 1'b0, 1'b0, 16'h0, 1'b1, exp_clip, TRP);
    end
    if (exp_l < 0) $display("unused");
  endtask

  task automatic run_burst(input logic [1:0] bank, input logic [12:0] row, input logic [8:0] col,
                           input logic [9:0] len, input int exp_l, input logic exp_clip,
                           input logic [15:0] base);
    bit seen;
    wr_data      = base;
    wr_addr      = {bank, row, col};
    wr_burst_len = len;
    push_burst(bank, row, col, exp_l, exp_clip, base, exp_l, 1'b1);
    ack_seen = 0;
    wr_en    = 1'b1;
    seen     = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (wr_end) seen = 1'b1;
    end
    wr_en = 1'b0;
    check("wr_end_seen", 64'(seen), 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("ack_count", 64'(ack_seen), 64'(exp_l));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit hit;
    rst          = 1'b1;
    init_end     = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = 24'h0;
    wr_burst_len = 10'd0;
    wr_data      = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {wr_cmd, wr_bank_addr, wr_sdram_addr, wr_ack, wr_end, wr_sdram_en, wr_sdram_data},
          {CMD_NOP, 2'b11, 13'h1fff, 1'b0, 1'b0, 1'b0, 16'h0});
    rst = 1'b0;

    // 1: grant without init_end is ignored
    wr_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_init_idle", {wr_cmd, wr_ack}, {CMD_NOP, 1'b0});
    end
    wr_en    = 1'b0;
    init_end = 1'b1;
    @(negedge clk);

    // 2: nominal L=4 burst
    run_burst(2'b01, 13'h0123, 9'h010, 10'd4, 4, 1'b0, 16'hA000);
    // 3: single-word bursts, L=1 and L=0
    run_burst(2'b10, 13'h0abc, 9'h005, 10'd1, 1, 1'b0, 16'hB000);
    run_burst(2'b00, 13'h1fff, 9'h1ff, 10'd0, 1, 1'b0, 16'hB100);
    // 4: full page and over-length request
    run_burst(2'b11, 13'h0001, 9'h000, 10'd512, 512, 1'b0, 16'h1000);
    run_burst(2'b00, 13'h0002, 9'h000, 10'd600, 512, 1'b0, 16'h2000);
    // 5: burst crossing the end of the page
`ifdef SDRAM_WR_PAGE_CLIP_EN
    run_burst(2'b01, 13'h0033, 9'h1FE, 10'd8, 2, 1'b1, 16'hD000);
`else
    run_burst(2'b01, 13'h0033, 9'h1FE, 10'd8, 8, 1'b0, 16'hD000);
`endif

    // 6: reset asserted on the third DATA clock
    wr_data      = 16'hC000;
    wr_addr      = {2'b10, 13'h0456, 9'h000};
    wr_burst_len = 10'd8;
    push_burst(2'b10, 13'h0456, 9'h000, 8, 1'b0, 16'hC000, 3, 1'b0);
    ack_seen = 0;
    wr_en    = 1'b1;
    hit      = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk);
      if (ack_seen >= 3) hit = 1'b1;
    end
    check("reach_data3", 64'(hit), 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_outputs",
             {wr_cmd, wr_bank_addr, wr_sdram_addr, wr_ack, wr_end, wr_sdram_en},
             {CMD_NOP, 2'b11, 13'h1fff, 1'b0, 1'b0, 1'b0});
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_drained", 64'(exp_q.size()), 64'd0);
    check("rst_ack_count", 64'(ack_seen), 64'd3);
    exp_q.delete();
    run_burst(2'b01, 13'h0777, 9'h020, 10'd4, 4, 1'b0, 16'hE000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
